tconv_scheduler: RTL and testbench
==================================

TCONV_SCHEDULER -- requirements
Module: tconv_scheduler

Interface
REQ-001 Parameter N, default 2, input feature-map side length; pixels processed = N*N.
REQ-002 Parameter K, default 3, kernel side; the multiplier produces K*K products per pixel.
REQ-003 Parameter TIMEOUT, default 64, maximum cycles to wait for any handshake before flagging an error.
REQ-004 Port clk  input  1  clock; all logic SHALL be clocked on its rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port start  input  1  one-cycle request to begin a full N*N pass; ignored unless idle.
REQ-007 Port abort  input  1  terminates the current pass and returns to idle.
REQ-008 Port pixel_idx  output  clog2(N*N)  current pixel index, driven to the multiplier and the decoder state input.
REQ-009 Port mult_start  output  1  one-cycle pulse that launches the multiplier for pixel_idx.
REQ-010 Port mult_done  input  1  multiplier products are valid.
REQ-011 Port dec_enable  output  1  decoder enable; the decoder acts on its rising edge.
REQ-012 Port dec_complete  input  1  decoder finished the current pixel.
REQ-013 Port busy  output  1  a pass is in progress.
REQ-014 Port done  output  1  one-cycle pulse when all N*N pixels have completed.
REQ-015 Port error  output  1  sticky timeout flag, cleared by rst or by an accepted start.

Function
REQ-016 States SHALL be IDLE, MULT, WAIT_MULT, DEC, WAIT_DEC, GAP, FINISH.
REQ-017 IDLE + start SHALL go to MULT with pixel_idx=0, busy=1, and error cleared.
REQ-018 MULT SHALL assert mult_start for exactly one cycle, then go to WAIT_MULT.
REQ-019 WAIT_MULT + mult_done SHALL go to DEC; mult_done sampled in any other state SHALL be ignored.
REQ-020 DEC SHALL raise dec_enable and go to WAIT_DEC; dec_enable SHALL stay high through WAIT_DEC.
REQ-021 WAIT_DEC + dec_complete SHALL drop dec_enable and go to GAP.
REQ-022 GAP SHALL hold dec_enable low for exactly one cycle, guaranteeing a fresh rising edge for the next pixel.
REQ-023 After GAP: if pixel_idx==N*N-1, go to FINISH; otherwise increment pixel_idx and go to MULT.
REQ-024 FINISH SHALL pulse done for one cycle, clear busy, and return to IDLE; pixel_idx holds its last value.
REQ-025 Minimum per-pixel latency: MULT→GAP with zero-wait handshakes = 5 cycles; pass latency = 5*N*N+1 cycles from start.
REQ-026 A wait counter SHALL reset on entering WAIT_MULT or WAIT_DEC; reaching TIMEOUT SHALL set error and go to IDLE with dec_enable=0 and no done pulse.
REQ-027 abort in any non-IDLE state SHALL go to IDLE the next cycle with dec_enable=0, busy=0, and no done pulse; abort takes priority over handshakes arriving in the same cycle.
REQ-028 start while busy SHALL be ignored; start and abort in the same IDLE cycle: abort wins and start is dropped.
REQ-029 pixel_idx arithmetic SHALL never wrap; the increment is guarded by the terminal check.

Reset
REQ-030 rst SHALL force IDLE, pixel_idx=0, mult_start=0, dec_enable=0, busy=0, done=0, error=0, wait counter=0.
REQ-031 rst mid-pass SHALL take effect the next edge regardless of handshake inputs.

Configuration
REQ-032 Macro TCONV_SCHED_CYCLE_COUNT_EN, when defined, SHALL add output cycle_count (32 bits): cleared on accepted start, incremented every busy cycle, held after done or abort; when undefined, the port and counter SHALL be absent.

Structure
REQ-033 State enum, state width, and the pixel-index width function SHALL live in shared package tconv_pkg.
REQ-034 Wait/timeout counting SHALL be a sub-module tconv_timeout_ctr (inputs clear and enable; output expired).

Verification
REQ-035 N=2, zero-wait handshakes, pulse start → pixel_idx 0,1,2,3 in order; done at cycle 21; busy high cycles 1-20.
REQ-036 Hold dec_complete high continuously → dec_enable low for exactly 1 cycle between each pixel; 4 rising edges total.
REQ-037 Never assert mult_done, TIMEOUT=8 → error=1 after 8 WAIT_MULT cycles; state IDLE; no done pulse; next start clears error.
REQ-038 Assert abort during WAIT_DEC of pixel 2 → next cycle dec_enable=0, busy=0, no done; a subsequent start restarts at pixel_idx=0.
REQ-039 Pulse start while busy at pixel 1 → no effect; pass completes normally with a single done pulse.
REQ-040 With TCONV_SCHED_CYCLE_COUNT_EN defined, N=2 zero-wait pass → cycle_count=20 after done.

Source files
------------

// File: rtl/tconv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tconv_pkg
// Description : Shared definitions for the transposed-convolution pixel
//               scheduler. Holds the state encoding, its width, and the
//               helper that sizes the pixel index for an N x N feature map.
// Revision    : 1.0 - initial release
// ============================================================================
package tconv_pkg;

    localparam int c_state_w = 3;

    typedef enum logic [c_state_w-1:0] {
        ST_IDLE      = 3'd0,
        ST_MULT      = 3'd1,
        ST_WAIT_MULT = 3'd2,
        ST_DEC       = 3'd3,
        ST_WAIT_DEC  = 3'd4,
        ST_GAP       = 3'd5,
        ST_FINISH    = 3'd6
    } state_t;

    // Width of an index covering n*n pixels; a 1x1 map still gets one bit so
    // the port never collapses to zero width.
    function automatic int pix_width(input int n);
        int w;
        w = $clog2(n * n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tconv_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module      : tconv_timeout_ctr
// Description : Handshake wait counter. Counts cycles while enable is high
//               and flags expired combinationally on the TIMEOUT-th waiting
//               cycle. clear (or rst) returns the count to zero.
// Ports       : clk     - clock, rising edge
//               rst     - synchronous active-high reset
//               clear   - zero the count
//               enable  - a handshake wait cycle is in progress
//               expired - this is the TIMEOUT-th consecutive wait cycle
// Revision    : 1.0 - initial release
// ============================================================================
module tconv_timeout_ctr #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int                 c_cnt_w = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(TIMEOUT - 1);

    logic [c_cnt_w-1:0] r_count;

    // The count saturates at the expiry value; the owner leaves the wait
    // state on expiry, so it never needs to go higher.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = enable && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/tconv_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tconv_scheduler
// Description : Sequences a full N*N pass of a transposed convolution. For
//               each pixel it launches the K*K multiplier, waits for its
//               products, then raises the decoder enable until the decoder
//               completes, followed by a one-cycle low gap so every pixel
//               sees a fresh enable rising edge. Handshake waits are bounded
//               by TIMEOUT cycles; expiry sets a sticky error and aborts.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               start, abort       - pass request / pass termination
//               pixel_idx          - current pixel to multiplier and decoder
//               mult_start         - one-cycle multiplier launch pulse
//               mult_done          - multiplier products valid
//               dec_enable         - decoder enable (acts on rising edge)
//               dec_complete       - decoder finished current pixel
//               busy, done, error  - pass status, completion pulse, timeout
//               cycle_count        - busy-cycle counter (optional)
// Options     : define TCONV_SCHED_CYCLE_COUNT_EN to add cycle_count.
// Revision    : 1.0 - initial release
// ============================================================================
module tconv_scheduler
    import tconv_pkg::*;
#(
    parameter int N       = 2,
    parameter int K       = 3,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    output logic [pix_width(N)-1:0] pixel_idx,
    output logic                    mult_start,
    input  logic                    mult_done,
    output logic                    dec_enable,
    input  logic                    dec_complete,
    output logic                    busy,
    output logic                    done,
    output logic                    error
`ifdef TCONV_SCHED_CYCLE_COUNT_EN
    ,
    output logic [31:0]             cycle_count
`endif
);

    localparam int                 c_pix_w    = pix_width(N);
    localparam logic [c_pix_w-1:0] c_last_pix = c_pix_w'(N * N - 1);

    generate
        if (N < 1 || K < 1 || TIMEOUT < 1) begin : g_bad_params
            $error("tconv_scheduler: N, K and TIMEOUT must all be at least 1");
        end
    endgenerate

    state_t             r_state;
    state_t             w_state_next;
    logic [c_pix_w-1:0] r_pixel_idx;
    logic               r_error;
    logic               w_start_ok;
    logic               w_last;
    logic               w_waiting;
    logic               w_expired;
    logic               w_set_error;
    logic               w_inc;

    // A start is only taken from idle, and a simultaneous abort drops it.
    assign w_start_ok = (r_state == ST_IDLE) && start && !abort;
    assign w_last     = (r_pixel_idx == c_last_pix);
    assign w_waiting  = (r_state == ST_WAIT_MULT) || (r_state == ST_WAIT_DEC);
    // Advance only on a GAP that is neither terminal nor aborted, so the
    // index can never wrap past the last pixel.
    assign w_inc      = (r_state == ST_GAP) && !abort && !w_last;

    // Every non-wait state holds the counter at zero, so each wait starts
    // from a fresh count.
    tconv_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk     (clk),
        .rst     (rst),
        .clear   (!w_waiting),
        .enable  (w_waiting),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_set_error  = 1'b0;
        mult_start   = 1'b0;
        dec_enable   = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;

        if (r_state != ST_IDLE && abort) begin
            // Abort outranks any handshake or expiry in the same cycle.
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        w_state_next = ST_MULT;
                    end
                end
                ST_MULT: begin
                    w_state_next = ST_WAIT_MULT;
                end
                ST_WAIT_MULT: begin
                    if (mult_done) begin
                        w_state_next = ST_DEC;
                    end else if (w_expired) begin
                        w_state_next = ST_IDLE;
                        w_set_error  = 1'b1;
                    end
                end
                ST_DEC: begin
                    w_state_next = ST_WAIT_DEC;
                end
                ST_WAIT_DEC: begin
                    if (dec_complete) begin
                        w_state_next = ST_GAP;
                    end else if (w_expired) begin
                        w_state_next = ST_IDLE;
                        w_set_error  = 1'b1;
                    end
                end
                ST_GAP: begin
                    w_state_next = w_last ? ST_FINISH : ST_MULT;
                end
                ST_FINISH: begin
                    w_state_next = ST_IDLE;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end

        // Moore outputs: decoded purely from the current state.
        case (r_state)
            ST_MULT:      begin mult_start = 1'b1; busy = 1'b1; end
            ST_WAIT_MULT: begin busy = 1'b1; end
            ST_DEC:       begin dec_enable = 1'b1; busy = 1'b1; end
            ST_WAIT_DEC:  begin dec_enable = 1'b1; busy = 1'b1; end
            ST_GAP:       begin busy = 1'b1; end
            ST_FINISH:    begin done = 1'b1; end
            default:      begin end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pixel_idx <= '0;
        end else if (w_start_ok) begin
            r_pixel_idx <= '0;
        end else if (w_inc) begin
            r_pixel_idx <= r_pixel_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_error <= 1'b0;
        end else if (w_start_ok) begin
            r_error <= 1'b0;
        end else if (w_set_error) begin
            r_error <= 1'b1;
        end
    end

    assign pixel_idx = r_pixel_idx;
    assign error     = r_error;

`ifdef TCONV_SCHED_CYCLE_COUNT_EN
    logic [31:0] r_cycle_count;

    // Counts busy cycles only, so the value freezes after done or abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_count <= '0;
        end else if (w_start_ok) begin
            r_cycle_count <= '0;
        end else if (busy) begin
            r_cycle_count <= r_cycle_count + 32'd1;
        end
    end

    assign cycle_count = r_cycle_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tconv_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_tconv_scheduler
// Description : Self-checking bench for tconv_scheduler (N=2, K=3,
//               TIMEOUT=8). A handshake responder answers mult_start and
//               dec_enable with programmable latency; expected pixel indices
//               are queued at start and popped at each mult_start. Honours
//               TCONV_SCHED_CYCLE_COUNT_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tconv_scheduler;

    localparam int c_n       = 2;
    localparam int c_pix     = c_n * c_n;
    localparam int c_timeout = 8;
    localparam int c_bound   = 400;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [1:0] pixel_idx;
    logic       mult_start;
    logic       mult_done;
    logic       dec_enable;
    logic       dec_complete;
    logic       busy;
    logic       done;
    logic       error;
`ifdef TCONV_SCHED_CYCLE_COUNT_EN
    logic [31:0] cycle_count;
`endif

    tconv_scheduler #(
        .N       (c_n),
        .K       (3),
        .TIMEOUT (c_timeout)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .pixel_idx    (pixel_idx),
        .mult_start   (mult_start),
        .mult_done    (mult_done),
        .dec_enable   (dec_enable),
        .dec_complete (dec_complete),
        .busy         (busy),
        .done         (done),
        .error        (error)
`ifdef TCONV_SCHED_CYCLE_COUNT_EN
        ,
        .cycle_count  (cycle_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int ml;        // mult_done latency after WAIT_MULT entry
        int dl;        // dec_complete latency after WAIT_DEC entry
        bit hold;      // hold dec_complete high continuously
        int exp_done;  // cycle of the done pulse, start edge = cycle 0
        int exp_busy;  // busy cycles in the pass
    } vec_t;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    int res_busy;
    int res_done_cyc;
    int res_done_cnt;
    int res_edges;
    int res_end;
    int res_abort_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one pass from start and acts as the multiplier/decoder.
    task automatic run_pass(input int ml, input int dl, input bit hold, input bit no_mult,
                            input int abort_pix, input int sbusy_pix);
        int  cyc;
        int  mcnt;
        int  dcnt;
        int  en_len;
        int  low_len;
        bit  prev_en;
        bit  ab_done;
        bit  sb_done;
        cyc = 0; mcnt = -1; dcnt = -1; en_len = 0; low_len = 0;
        prev_en = 1'b0; ab_done = 1'b0; sb_done = 1'b0;
        res_busy = 0; res_done_cyc = -1; res_done_cnt = 0; res_edges = 0;
        res_end = -1; res_abort_cyc = -1;
        exp_q.delete();
        for (int i = 0; i < c_pix; i++) exp_q.push_back(i);
        start = 1'b1; abort = 1'b0; mult_done = 1'b0; dec_complete = 1'b0;
        step();
        cyc++;
        start = 1'b0;
        for (int k = 0; k < c_bound; k++) begin
            if (done) begin
                res_done_cnt++;
                res_done_cyc = cyc;
            end
            if (!busy) begin
                res_end = cyc;
                break;
            end
            res_busy++;
            mult_done = 1'b0; dec_complete = hold; abort = 1'b0; start = 1'b0;
            if (mult_start) begin
                if (exp_q.size() == 0) check("extra_mult_start", 1, 0);
                else check("pixel_idx_at_mult_start", {30'd0, pixel_idx}, exp_q.pop_front());
                mcnt = ml;
            end else if (mcnt >= 0) begin
                if (mcnt == 0) begin
                    mult_done = !no_mult;
                    mcnt = -1;
                end else begin
                    mcnt--;
                end
            end
            if (dec_enable && !prev_en) begin
                res_edges++;
                if (res_edges > 1) check("dec_enable_low_len", low_len, ml + 3);
                en_len = 1;
                dcnt = dl;
            end else if (dec_enable) begin
                en_len++;
                if (dcnt >= 0) begin
                    if (dcnt == 0) begin
                        dec_complete = 1'b1;
                        dcnt = -1;
                    end else begin
                        dcnt--;
                    end
                end
            end else begin
                if (prev_en) begin
                    check("dec_enable_high_len", en_len, dl + 2);
                    low_len = 0;
                end
                low_len++;
            end
            if (abort_pix >= 0 && !ab_done && dec_enable && prev_en && pixel_idx == 2'(abort_pix)) begin
                abort = 1'b1;
                dec_complete = 1'b1;
                ab_done = 1'b1;
                res_abort_cyc = cyc;
            end
            if (sbusy_pix >= 0 && !sb_done && pixel_idx == 2'(sbusy_pix)) begin
                start = 1'b1;
                sb_done = 1'b1;
            end
            prev_en = dec_enable;
            step();
            cyc++;
        end
        if (res_end < 0) check("pass_cycle_bound", 0, 1);
        mult_done = 1'b0; dec_complete = 1'b0; abort = 1'b0; start = 1'b0;
    endtask

    initial begin
        vec_t vecs[5];
        vecs[0] = '{ml: 0, dl: 0, hold: 1'b0, exp_done: 21, exp_busy: 20};
        vecs[1] = '{ml: 0, dl: 0, hold: 1'b1, exp_done: 21, exp_busy: 20};
        vecs[2] = '{ml: 2, dl: 1, hold: 1'b0, exp_done: 33, exp_busy: 32};
        vecs[3] = '{ml: 1, dl: 4, hold: 1'b0, exp_done: 41, exp_busy: 40};
        vecs[4] = '{ml: 6, dl: 6, hold: 1'b0, exp_done: 69, exp_busy: 68};

        rst = 1'b1; start = 1'b0; abort = 1'b0; mult_done = 1'b0; dec_complete = 1'b0;
        repeat (3) step();
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_mult_start", mult_start, 0);
        check("reset_dec_enable", dec_enable, 0);
        check("reset_error", error, 0);
        check("reset_pixel_idx", pixel_idx, 0);
        rst = 1'b0;
        step();

        // Table-driven full passes with different handshake latencies.
        for (int r = 0; r < 5; r++) begin
            run_pass(vecs[r].ml, vecs[r].dl, vecs[r].hold, 1'b0, -1, -1);
            check("done_cycle", res_done_cyc, vecs[r].exp_done);
            check("done_pulses", res_done_cnt, 1);
            check("busy_cycles", res_busy, vecs[r].exp_busy);
            check("dec_rising_edges", res_edges, c_pix);
            check("pixels_unlaunched", exp_q.size(), 0);
            check("final_pixel_idx", pixel_idx, c_pix - 1);
            check("error_after_pass", error, 0);
`ifdef TCONV_SCHED_CYCLE_COUNT_EN
            check("cycle_count", cycle_count, vecs[r].exp_busy);
`endif
            step();
            check("done_single_cycle", done, 0);
            check("pixel_idx_held", pixel_idx, c_pix - 1);
        end

        // start and abort together in idle: abort wins.
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle_busy", busy, 0);
        check("start_abort_idle_mult", mult_start, 0);
        step();
        check("start_abort_idle_busy2", busy, 0);

        // Multiplier never answers: timeout after 8 WAIT_MULT cycles.
        run_pass(0, 0, 1'b0, 1'b1, -1, -1);
        check("timeout_end_cycle", res_end, 10);
        check("timeout_busy_cycles", res_busy, 9);
        check("timeout_error", error, 1);
        check("timeout_no_done", res_done_cnt, 0);
        check("timeout_dec_enable", dec_enable, 0);
        repeat (3) step();
        check("error_sticky", error, 1);
        run_pass(0, 0, 1'b0, 1'b0, -1, -1);
        check("restart_after_timeout_done", res_done_cyc, 21);
        check("error_cleared_by_start", error, 0);
        step();

        // Abort during WAIT_DEC of pixel 2, with dec_complete in the same cycle.
        run_pass(0, 2, 1'b0, 1'b0, 2, -1);
        check("abort_cycle", res_abort_cyc, 18);
        check("abort_end_cycle", res_end, 19);
        check("abort_dec_enable", dec_enable, 0);
        check("abort_busy", busy, 0);
        check("abort_no_done", res_done_cnt, 0);
        check("abort_pixels_left", exp_q.size(), 1);
        step();
        run_pass(0, 0, 1'b0, 1'b0, -1, -1);
        check("after_abort_done", res_done_cyc, 21);
        check("after_abort_pixels", exp_q.size(), 0);
        step();

        // start pulsed while busy at pixel 1 is ignored.
        run_pass(0, 0, 1'b0, 1'b0, -1, 1);
        check("busy_start_done_cycle", res_done_cyc, 21);
        check("busy_start_done_pulses", res_done_cnt, 1);
        check("busy_start_pixels", exp_q.size(), 0);
        step();
        check("busy_start_idle_after", busy, 0);

        // Reset mid-pass while handshakes are high.
        start = 1'b1;
        step();
        start = 1'b0; mult_done = 1'b1; dec_complete = 1'b1;
        repeat (7) step();
        check("midpass_pixel_idx", pixel_idx, 1);
        check("midpass_dec_enable", dec_enable, 1);
        rst = 1'b1;
        step();
        check("rst_midpass_busy", busy, 0);
        check("rst_midpass_dec_enable", dec_enable, 0);
        check("rst_midpass_pixel_idx", pixel_idx, 0);
        check("rst_midpass_mult_start", mult_start, 0);
        rst = 1'b0; mult_done = 1'b0; dec_complete = 1'b0;
        step();
        check("rst_midpass_stays_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
